observer_uart_rx: RTL and testbench

//  8-bit UART receiver (8N1; 8E1/8O1 with parity option), companion to the observer UART transmitter.

---
 rtl/observer_uart_rx_if.sv | 17 +
 rtl/observer_uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_observer_uart_rx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/observer_uart_rx_if.sv
// Byte/handshake bundle between the observer UART receiver (master) and its consumer (slave).
// The slave side also owns the serial line that feeds the receiver.
interface observer_uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  modport master (input rx, ready,
                  output data, valid, frame_err, overrun, parity_err, busy);
  modport slave  (output rx, ready,
                  input data, valid, frame_err, overrun, parity_err, busy);
endinterface

// File: rtl/observer_uart_rx.sv
// observer_uart_rx: 8N1 UART receiver with centre sampling and a valid/ready byte output.
// Define UART_RX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1) and live parity_err.
module observer_uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int PARITY_ODD   = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  observer_uart_rx_if.master bus
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HI
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          busy_q;
  logic          byte_ok;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_bad;
  logic parity_err_q;

  // A bad parity bit drops the byte even when the stop bit is good.
  assign byte_ok        = rx_s & ~par_bad;
  assign bus.parity_err = parity_err_q;
`else
  logic unused_parity_odd;

  assign unused_parity_odd = (PARITY_ODD != 0);
  assign byte_ok           = rx_s;
  assign bus.parity_err    = 1'b0;
`endif

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta     <= bus.rx;
      rx_s        <= rx_meta;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt    <= HALF_LOAD;
            busy_q <= 1'b1;
            state  <= START;
          end
        end

        // Re-check the start bit at its centre so short glitches are ignored.
        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              cnt   <= FULL_LOAD;
              idx   <= '0;
              state <= DATA;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        DATA: begin
          if (cnt == '0) begin
            sh  <= {rx_s, sh[7:1]};
            cnt <= FULL_LOAD;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == '0) begin
            par_bad <= (rx_s != (^sh ^ PAR_ODD));
            cnt     <= FULL_LOAD;
            state   <= STOP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif

        // Leaving at the stop-bit centre gives half a bit of margin for the next start edge.
        STOP: begin
          if (cnt == '0) begin
            frame_err_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= par_bad;
`endif
            if (byte_ok) begin
              if (!valid_q || bus.ready) begin
                data_q  <= sh;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
            if (rx_s) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= WAIT_HI;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        WAIT_HI: begin
          if (rx_s) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_observer_uart_rx.sv
// Self-checking bench for observer_uart_rx: table of single frames, then hand-written
// overrun, glitch, break, mid-frame reset and (with UART_RX_PARITY_EN) parity sequences.
module tb_observer_uart_rx;

  localparam int CPB     = 8;
  localparam bit PAR_ODD = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_acc;
    int         exp_frame;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  observer_uart_rx_if bus();

  observer_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         acc_total    = 0;
  int         frame_total  = 0;
  int         over_total   = 0;
  int         par_total    = 0;
  int         valid_cycles = 0;
  int         busy_cycles  = 0;
  logic [7:0] last_acc     = 8'h00;

  int s_acc, s_frame, s_over, s_par, s_valid, s_busy;

  // Event counters sampled mid-cycle, away from the rising edge the DUT uses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid && bus.ready) begin
        acc_total = acc_total + 1;
        last_acc  = bus.data;
      end
      if (bus.frame_err)  frame_total  = frame_total + 1;
      if (bus.overrun)    over_total   = over_total + 1;
      if (bus.parity_err) par_total    = par_total + 1;
      if (bus.valid)      valid_cycles = valid_cycles + 1;
      if (bus.busy)       busy_cycles  = busy_cycles + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    s_acc   = acc_total;
    s_frame = frame_total;
    s_over  = over_total;
    s_par   = par_total;
    s_valid = valid_cycles;
    s_busy  = busy_cycles;
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ^b ^ PAR_ODD;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks = n_checks + 1;
    if (actual !== expected) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_bit(input logic v);
    bus.rx = v;
    tick(CPB);
  endtask

  // Leaves the line at the stop-bit level so a low stop bit can run on into a break.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int k = 0; k < 8; k++) send_bit(b[k]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) $display("[TB] note: parity argument unused");
`endif
    send_bit(stop);
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    snap();
    send_frame(v.data, good_par(v.data), v.stop);
    bus.rx = 1'b1;
    tick(20);
    checkOutput($sformatf("vec%0d_accepted", i), acc_total - s_acc, v.exp_acc);
    checkOutput($sformatf("vec%0d_valid_cycles", i), valid_cycles - s_valid, v.exp_acc);
    checkOutput($sformatf("vec%0d_frame_err", i), frame_total - s_frame, v.exp_frame);
    checkOutput($sformatf("vec%0d_overrun", i), over_total - s_over, 0);
    checkOutput($sformatf("vec%0d_parity_err", i), par_total - s_par, 0);
    checkOutput($sformatf("vec%0d_busy_idle", i), bus.busy, 0);
    if (v.exp_acc != 0) begin
      checkOutput($sformatf("vec%0d_data", i), last_acc, v.data);
    end
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b1, 1, 0};
    vecs[4] = '{8'h55, 1'b0, 0, 1};
    vecs[5] = '{8'h81, 1'b1, 1, 0};

    bus.rx    = 1'b1;
    bus.ready = 1'b1;
    rst       = 1'b1;
    tick(3);
    checkOutput("reset_valid", bus.valid, 0);
    checkOutput("reset_data", bus.data, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_frame_err", bus.frame_err, 0);
    checkOutput("reset_overrun", bus.overrun, 0);
    checkOutput("reset_parity_err", bus.parity_err, 0);
    rst = 1'b0;
    tick(4);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Held byte is not overwritten; the second frame only raises overrun.
    $display("[TB] overrun sequence");
    bus.ready = 1'b0;
    snap();
    send_frame(8'hA5, good_par(8'hA5), 1'b1);
    send_frame(8'h3C, good_par(8'h3C), 1'b1);
    tick(10);
    checkOutput("ovr_pulses", over_total - s_over, 1);
    checkOutput("ovr_valid_held", bus.valid, 1);
    checkOutput("ovr_data_held", bus.data, 8'hA5);
    checkOutput("ovr_no_accept", acc_total - s_acc, 0);
    bus.ready = 1'b1;
    tick(1);
    checkOutput("ovr_valid_drop", bus.valid, 0);
    checkOutput("ovr_accepted", acc_total - s_acc, 1);
    checkOutput("ovr_accepted_data", last_acc, 8'hA5);
    tick(10);

    $display("[TB] glitch sequence");
    snap();
    bus.rx = 1'b0;
    tick(2);
    bus.rx = 1'b1;
    tick(20);
    checkOutput("glitch_was_busy", (busy_cycles - s_busy) > 0, 1);
    checkOutput("glitch_busy_idle", bus.busy, 0);
    checkOutput("glitch_no_valid", valid_cycles - s_valid, 0);
    checkOutput("glitch_no_frame_err", frame_total - s_frame, 0);

    $display("[TB] break sequence");
    snap();
    send_frame(8'h55, good_par(8'h55), 1'b0);
    tick(40);
    bus.rx = 1'b1;
    tick(20);
    checkOutput("break_frame_err", frame_total - s_frame, 1);
    checkOutput("break_no_valid", valid_cycles - s_valid, 0);
    checkOutput("break_busy_idle", bus.busy, 0);
    snap();
    send_frame(8'h12, good_par(8'h12), 1'b1);
    tick(20);
    checkOutput("after_break_accepted", acc_total - s_acc, 1);
    checkOutput("after_break_data", last_acc, 8'h12);

    $display("[TB] mid-frame reset sequence");
    bus.rx = 1'b0;
    tick(30);
    checkOutput("pre_reset_busy", bus.busy, 1);
    rst    = 1'b1;
    bus.rx = 1'b1;
    tick(1);
    checkOutput("rst_valid", bus.valid, 0);
    checkOutput("rst_data", bus.data, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_frame_err", bus.frame_err, 0);
    checkOutput("rst_overrun", bus.overrun, 0);
    rst = 1'b0;
    tick(20);
    snap();
    send_frame(8'hFF, good_par(8'hFF), 1'b1);
    tick(20);
    checkOutput("after_rst_accepted", acc_total - s_acc, 1);
    checkOutput("after_rst_data", last_acc, 8'hFF);
    checkOutput("after_rst_frame_err", frame_total - s_frame, 0);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity sequence");
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    tick(20);
    checkOutput("par_good_accepted", acc_total - s_acc, 1);
    checkOutput("par_good_data", last_acc, 8'h07);
    checkOutput("par_good_no_err", par_total - s_par, 0);
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    tick(20);
    checkOutput("par_bad_err", par_total - s_par, 1);
    checkOutput("par_bad_no_valid", valid_cycles - s_valid, 0);
    checkOutput("par_bad_no_frame_err", frame_total - s_frame, 0);
    snap();
    send_frame(8'h07, 1'b0, 1'b0);
    bus.rx = 1'b1;
    tick(20);
    checkOutput("par_both_parity_err", par_total - s_par, 1);
    checkOutput("par_both_frame_err", frame_total - s_frame, 1);
    checkOutput("par_both_no_valid", valid_cycles - s_valid, 0);
`endif

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
